scarv_cop_cpu_if: RTL and testbench

Host-CPU-facing instruction front end of the SCARV crypto coprocessor. It accepts ISE instructions and their GPR rs1 operand from the CPU over a valid/ack handshake and buffers them in a 2-entry queue. It presents the queue head to the combinational instruction decoder, then either dispatches the instruction to the execute units or rejects it as illegal. It returns the writeback/status response to the CPU and bounds execute latency with a watchdog.

---
 rtl/scarv_cop_cpu_if.sv | 182 ++++++++++++++++++
 tb/tb_scarv_cop_cpu_if.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_cpu_if.sv
// CPU-facing instruction front end of the SCARV coprocessor.
// Buffers {encoding, rs1} pairs in a 2-entry queue. Each entry is decoded,
// then either dispatched or rejected as illegal. The result goes back to the
// CPU, and a watchdog bounds the time spent in execute.
module scarv_cop_cpu_if #(
   parameter int unsigned EX_TIMEOUT = 64
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        cpu_insn_req,
   output logic        cpu_insn_ack,
   input  logic [31:0] cpu_insn_enc,
   input  logic [31:0] cpu_insn_rs1,
   output logic        cpu_rsp_valid,
   input  logic        cpu_rsp_ack,
   output logic [1:0]  cpu_rsp_status,
   output logic        cpu_rsp_wen,
   output logic [4:0]  cpu_rsp_rd,
   output logic [31:0] cpu_rsp_wdata,
   output logic [31:0] id_encoded,
   input  logic        id_exception,
   input  logic [4:0]  id_rd,
   output logic        ex_start,
   output logic [31:0] ex_rs1,
   output logic        ex_abort,
   input  logic        ex_done,
   input  logic        ex_error,
   input  logic        ex_wen,
   input  logic [31:0] ex_wdata
);

   localparam logic [1:0] StatusOk      = 2'd0;
   localparam logic [1:0] StatusIllegal = 2'd1;
   localparam logic [1:0] StatusExError = 2'd2;
   localparam logic [1:0] StatusTimeout = 2'd3;

   // Watchdog value seen in the last allowed EXEC cycle.
   localparam logic [7:0] WdogLast = 8'(EX_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StDecode, StExec, StResp} state_e;

   // Instruction queue
   logic [31:0] q_enc_q [2];
   logic [31:0] q_rs1_q [2];
   logic        head_q, tail_q;
   logic [1:0]  count_q, count_d;
   logic        push, pop;

   // Control and response state
   state_e      state_q, state_d;
   logic [7:0]  wdog_q, wdog_d;
   logic [4:0]  id_rd_q, id_rd_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [1:0]  status_q, status_d;
   logic        wen_q, wen_d;
   logic [31:0] wdata_q, wdata_d;
   logic        ex_start_q, ex_start_d;

   // A full queue refuses pushes even while it is popping (no write-through).
   assign cpu_insn_ack = (count_q != 2'd2);
   assign push         = cpu_insn_req && cpu_insn_ack;
   assign pop          = (state_q == StResp) && cpu_rsp_ack;
   assign count_d      = count_q + {1'b0, push} - {1'b0, pop};

   assign id_encoded = (count_q != 2'd0) ? q_enc_q[head_q] : '0;
   assign ex_rs1     = (count_q != 2'd0) ? q_rs1_q[head_q] : '0;

   // The abort must be seen in the timeout cycle itself and must be withheld
   // when ex_done lands in that cycle. For this reason it is decoded from
   // registered state rather than registered.
   assign ex_abort = (state_q == StExec) && !ex_done && (wdog_q == WdogLast);

   assign cpu_rsp_valid  = rsp_valid_q;
   assign cpu_rsp_status = status_q;
   assign cpu_rsp_wen    = wen_q;
   assign cpu_rsp_rd     = wen_q ? id_rd_q : '0;
   assign cpu_rsp_wdata  = wdata_q;
   assign ex_start       = ex_start_q;

   // Queue storage and pointers.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         for (int i = 0; i < 2; i++) begin
            q_enc_q[i] <= '0;
            q_rs1_q[i] <= '0;
         end
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push) begin
            q_enc_q[tail_q] <= cpu_insn_enc;
            q_rs1_q[tail_q] <= cpu_insn_rs1;
            tail_q          <= ~tail_q;
         end
         if (pop) begin
            head_q <= ~head_q;
         end
         count_q <= count_d;
      end
   end

   // Next-state, watchdog and response capture.
   always_comb begin
      state_d     = state_q;
      wdog_d      = wdog_q;
      id_rd_d     = id_rd_q;
      rsp_valid_d = rsp_valid_q;
      status_d    = status_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      ex_start_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != 2'd0) begin
               state_d = StDecode;
            end
         end
         StDecode: begin
            id_rd_d = id_rd;
            if (id_exception) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               status_d    = StatusIllegal;
               wen_d       = 1'b0;
               wdata_d     = '0;
            end else begin
               state_d    = StExec;
               wdog_d     = '0;
               ex_start_d = 1'b1;
            end
         end
         StExec: begin
            wdog_d = wdog_q + 8'd1;
            if (ex_done) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               status_d    = ex_error ? StatusExError : StatusOk;
               wen_d       = ex_wen && !ex_error;
               wdata_d     = ex_wdata;
            end else if (wdog_q == WdogLast) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               status_d    = StatusTimeout;
               wen_d       = 1'b0;
               wdata_d     = '0;
            end
         end
         StResp: begin
            if (cpu_rsp_ack) begin
               rsp_valid_d = 1'b0;
               state_d     = (count_d != 2'd0) ? StDecode : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and response registers.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q     <= StIdle;
         wdog_q      <= '0;
         id_rd_q     <= '0;
         rsp_valid_q <= 1'b0;
         status_q    <= StatusOk;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         ex_start_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wdog_q      <= wdog_d;
         id_rd_q     <= id_rd_d;
         rsp_valid_q <= rsp_valid_d;
         status_q    <= status_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         ex_start_q  <= ex_start_d;
      end
   end

endmodule

// File: tb/tb_scarv_cop_cpu_if.sv
// Self-checking bench for scarv_cop_cpu_if. The bench acts as the decoder,
// the execute unit and the CPU, and predicts every response from the
// instruction rules directly.
module tb_scarv_cop_cpu_if;

   localparam int unsigned T = 4;
   localparam logic [31:0] K = 32'h5A5A_5A5A;

   logic        g_clk, g_resetn;
   logic        cpu_insn_req, cpu_insn_ack;
   logic [31:0] cpu_insn_enc, cpu_insn_rs1;
   logic        cpu_rsp_valid, cpu_rsp_ack;
   logic [1:0]  cpu_rsp_status;
   logic        cpu_rsp_wen;
   logic [4:0]  cpu_rsp_rd;
   logic [31:0] cpu_rsp_wdata;
   logic [31:0] id_encoded;
   logic        id_exception;
   logic [4:0]  id_rd;
   logic        ex_start, ex_abort;
   logic [31:0] ex_rs1;
   logic        ex_done, ex_error, ex_wen;
   logic [31:0] ex_wdata;

   int checks = 0;
   int errors = 0;

   scarv_cop_cpu_if #(.EX_TIMEOUT(T)) dut (
      .g_clk         (g_clk),
      .g_resetn      (g_resetn),
      .cpu_insn_req  (cpu_insn_req),
      .cpu_insn_ack  (cpu_insn_ack),
      .cpu_insn_enc  (cpu_insn_enc),
      .cpu_insn_rs1  (cpu_insn_rs1),
      .cpu_rsp_valid (cpu_rsp_valid),
      .cpu_rsp_ack   (cpu_rsp_ack),
      .cpu_rsp_status(cpu_rsp_status),
      .cpu_rsp_wen   (cpu_rsp_wen),
      .cpu_rsp_rd    (cpu_rsp_rd),
      .cpu_rsp_wdata (cpu_rsp_wdata),
      .id_encoded    (id_encoded),
      .id_exception  (id_exception),
      .id_rd         (id_rd),
      .ex_start      (ex_start),
      .ex_rs1        (ex_rs1),
      .ex_abort      (ex_abort),
      .ex_done       (ex_done),
      .ex_error      (ex_error),
      .ex_wen        (ex_wen),
      .ex_wdata      (ex_wdata)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   // Bench decoder: opcode 0x2B is legal; rd is an arbitrary field mapping.
   assign id_exception = (id_encoded[6:0] != 7'h2B);
   assign id_rd        = id_encoded[11:7] ^ 5'd5;

   function automatic logic [4:0] dec_rd(input logic [31:0] enc);
      return enc[11:7] ^ 5'd5;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".ack"}, 32'(cpu_insn_ack), 32'd1);
      check({tag, ".rsp_valid"}, 32'(cpu_rsp_valid), 32'd0);
      check({tag, ".status"}, 32'(cpu_rsp_status), 32'd0);
      check({tag, ".wen"}, 32'(cpu_rsp_wen), 32'd0);
      check({tag, ".rd"}, 32'(cpu_rsp_rd), 32'd0);
      check({tag, ".wdata"}, cpu_rsp_wdata, 32'd0);
      check({tag, ".id_encoded"}, id_encoded, 32'd0);
      check({tag, ".ex_start"}, 32'(ex_start), 32'd0);
      check({tag, ".ex_rs1"}, ex_rs1, 32'd0);
      check({tag, ".ex_abort"}, 32'(ex_abort), 32'd0);
   endtask

   // One instruction through an empty front end. k = EXEC cycle (1-based) of
   // ex_done, 0 = never. Period c counts edges since the push edge.
   task automatic run_single(input logic [31:0] enc, input int k, input bit err,
                             input bit wen, input logic [31:0] wd, input bit junk,
                             input int hold);
      logic [31:0] rs1;
      bit          legal, tmo, exp_wen;
      int          lat, exp_status;
      legal      = (enc[6:0] == 7'h2B);
      tmo        = legal && (k == 0 || k > int'(T));
      lat        = !legal ? 2 : (tmo ? 2 + int'(T) : 2 + k);
      exp_status = !legal ? 1 : (tmo ? 3 : (err ? 2 : 0));
      exp_wen    = legal && !tmo && wen && !err;
      rs1        = $urandom;
      @(posedge g_clk); #1;
      cpu_insn_req = 1'b1;
      cpu_insn_enc = enc;
      cpu_insn_rs1 = rs1;
      #1 check("push.ack", 32'(cpu_insn_ack), 32'd1);
      for (int c = 0; c <= lat + hold + 1; c++) begin
         @(posedge g_clk); #1;
         cpu_insn_req = 1'b0;
         cpu_insn_enc = $urandom;
         cpu_rsp_ack  = (c >= lat + hold);
         if (legal && k > 0 && c == 1 + k) begin
            ex_done = 1'b1; ex_error = err; ex_wen = wen; ex_wdata = wd;
         end else if (junk && (c <= 1 || c >= lat)) begin
            ex_done = 1'($urandom); ex_error = 1'($urandom);
            ex_wen = 1'($urandom); ex_wdata = $urandom;
         end else begin
            ex_done = 1'b0; ex_error = 1'b0; ex_wen = 1'b0; ex_wdata = '0;
         end
         #1;
         check("ex_start", 32'(ex_start), 32'(legal && c == 2));
         check("ex_abort", 32'(ex_abort), 32'(tmo && c == 1 + int'(T)));
         check("rsp_valid", 32'(cpu_rsp_valid), 32'(c >= lat && c <= lat + hold));
         check("id_encoded", id_encoded, (c <= lat + hold) ? enc : 32'd0);
         if (c >= 1 && c <= lat + hold) check("ex_rs1", ex_rs1, rs1);
         if (c == lat) begin
            check("rsp.status", 32'(cpu_rsp_status), 32'(exp_status));
            check("rsp.wen", 32'(cpu_rsp_wen), 32'(exp_wen));
            check("rsp.rd", 32'(cpu_rsp_rd), exp_wen ? 32'(dec_rd(enc)) : 32'd0);
            if (exp_status == 0 || exp_status == 2) check("rsp.wdata", cpu_rsp_wdata, wd);
         end
         if (c == lat + hold + 1) check("after.ack", 32'(cpu_insn_ack), 32'd1);
      end
      cpu_rsp_ack = 1'b0;
      ex_done = 1'b0; ex_error = 1'b0; ex_wen = 1'b0; ex_wdata = '0;
   endtask

   typedef struct {
      logic [31:0] enc;
      logic [31:0] rs1;
   } item_t;

   // Drive one cycle of the queue test: execute unit always done, echoes rs1^K.
   task automatic q_cycle(input bit req, input item_t it, input bit rack);
      @(posedge g_clk); #1;
      cpu_insn_req = req;
      cpu_insn_enc = it.enc;
      cpu_insn_rs1 = it.rs1;
      cpu_rsp_ack  = rack;
      ex_done = 1'b1; ex_error = 1'b0; ex_wen = 1'b1; ex_wdata = ex_rs1 ^ K;
      #1;
   endtask

   function automatic item_t new_item();
      item_t it;
      it.enc      = $urandom;
      it.enc[6:0] = 7'h2B;
      it.rs1      = $urandom;
      return it;
   endfunction

   item_t it_a, it_b, it_c, it_exp;
   item_t expq[$];

   initial begin
      g_resetn = 1'b0;
      cpu_insn_req = 1'b0; cpu_insn_enc = '0; cpu_insn_rs1 = '0; cpu_rsp_ack = 1'b0;
      ex_done = 1'b0; ex_error = 1'b0; ex_wen = 1'b0; ex_wdata = '0;
      repeat (2) @(posedge g_clk);
      #1 check_reset_outputs("reset");
      #2 g_resetn = 1'b1;

      // Directed cases
      run_single(32'h0000_102B, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
      run_single(32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
      run_single(32'h0000_0AAB, 0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 0);
      run_single(32'h0000_0AAB, int'(T), 1'b0, 1'b1, 32'h1234_5678, 1'b0, 0);
      run_single(32'h0000_03AB, 2, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 2);

      // Queue: two accepts, third refused until a response is acknowledged
      it_a = new_item(); it_b = new_item(); it_c = new_item();
      q_cycle(1'b1, it_a, 1'b0); check("q.ack1", 32'(cpu_insn_ack), 32'd1);
      q_cycle(1'b1, it_b, 1'b0); check("q.ack2", 32'(cpu_insn_ack), 32'd1);
      q_cycle(1'b1, it_c, 1'b0); check("q.ack3", 32'(cpu_insn_ack), 32'd0);
      q_cycle(1'b1, it_c, 1'b0); check("q.ack4", 32'(cpu_insn_ack), 32'd0);
      q_cycle(1'b1, it_c, 1'b0);
      check("q.a.valid", 32'(cpu_rsp_valid), 32'd1);
      check("q.a.status", 32'(cpu_rsp_status), 32'd0);
      check("q.a.rd", 32'(cpu_rsp_rd), 32'(dec_rd(it_a.enc)));
      check("q.a.wdata", cpu_rsp_wdata, it_a.rs1 ^ K);
      check("q.ack5", 32'(cpu_insn_ack), 32'd0);
      q_cycle(1'b1, it_c, 1'b0); check("q.a.hold", 32'(cpu_rsp_valid), 32'd1);
      q_cycle(1'b1, it_c, 1'b1); check("q.ack_pop", 32'(cpu_insn_ack), 32'd0);
      q_cycle(1'b1, it_c, 1'b0); check("q.ack_after", 32'(cpu_insn_ack), 32'd1);
      expq.push_back(it_b);
      expq.push_back(it_c);
      for (int i = 0; i < 20; i++) begin
         q_cycle(1'b0, it_a, 1'b1);
         if (cpu_rsp_valid) begin
            check("q.rsp_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
               it_exp = expq.pop_front();
               check("q.status", 32'(cpu_rsp_status), 32'd0);
               check("q.rd", 32'(cpu_rsp_rd), 32'(dec_rd(it_exp.enc)));
               check("q.wdata", cpu_rsp_wdata, it_exp.rs1 ^ K);
            end
         end
      end
      check("q.drained", expq.size(), 32'd0);
      cpu_rsp_ack = 1'b0;
      ex_done = 1'b0; ex_wen = 1'b0; ex_wdata = '0;

      // Randomized instructions
      for (int n = 0; n < 30; n++) begin
         logic [31:0] enc;
         enc = $urandom;
         if ($urandom_range(0, 3) != 0) enc[6:0] = 7'h2B;
         run_single(enc, $urandom_range(0, 6), 1'($urandom), 1'($urandom), $urandom,
                    1'($urandom), $urandom_range(0, 2));
      end

      // Asynchronous reset mid-EXEC with two entries queued
      it_a = new_item(); it_b = new_item();
      @(posedge g_clk); #1;
      cpu_insn_req = 1'b1; cpu_insn_enc = it_a.enc; cpu_insn_rs1 = it_a.rs1;
      @(posedge g_clk); #1;
      cpu_insn_enc = it_b.enc; cpu_insn_rs1 = it_b.rs1;
      @(posedge g_clk); #1;
      cpu_insn_req = 1'b0;
      @(posedge g_clk); #2;
      check("rst.pre_start", 32'(ex_start), 32'd1);
      #1 g_resetn = 1'b0;
      #1 check_reset_outputs("rst.async");
      @(posedge g_clk); #3 g_resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge g_clk); #1;
         ex_done = 1'($urandom); ex_wen = 1'($urandom); ex_wdata = $urandom;
         #1;
         check("rst.no_rsp", 32'(cpu_rsp_valid), 32'd0);
         check("rst.no_abort", 32'(ex_abort), 32'd0);
         check("rst.no_start", 32'(ex_start), 32'd0);
         check("rst.ack", 32'(cpu_insn_ack), 32'd1);
         check("rst.empty", id_encoded, 32'd0);
      end
      ex_done = 1'b0; ex_wen = 1'b0; ex_wdata = '0;
      run_single(32'h0000_102B, 3, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
